// File: rtl/sersub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The FSM encoding is fixed so that state values stay stable across builds.
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

  // Bit counter width for a given operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor cell: diff = a - b - c, br = borrow out.
// Purely combinational.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic br
);

  assign diff = a ^ b ^ c;
  assign br   = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first; result valid WIDTH cycles after accept; one op in flight.
// Backpressure: in_ready only in IDLE, result held in DONE until out_ready. Optional ovf via SERSUB_OVF_EN.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             accept;
  logic             last_bit;
  logic             cell_diff;
  logic             cell_br;

  fullsubtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (brw),
    .diff (cell_diff),
    .br   (cell_br)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results land in diff_r/bout_r only at the last bit, so the outputs never
  // show partial sums and stay put through DONE and the following IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {cell_diff, res_sh[WIDTH-1:1]};
      brw    <= cell_br;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        diff_r <= {cell_diff, res_sh[WIDTH-1:1]};
        bout_r <= cell_br;
      end
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;

`ifdef SERSUB_OVF_EN
  logic ovf_r;

  // At the last bit brw is the borrow into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (last_bit) begin
      ovf_r <= brw ^ cell_br;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule
